// File: rtl/glb_tile_evt_pipe_pkg.sv
// Shared parameters for the global buffer tile event pipeline.
// Holds the default channel counts and symbolic channel indices used by
// the tile wrapper, the core and anything that decodes the pulse vectors.
package global_buffer_param;

    localparam int unsigned GLB_NUM_START = 2;
    localparam int unsigned GLB_NUM_INTR  = 3;

    // Start-pulse channel indices
    localparam int unsigned START_STRM = 0;
    localparam int unsigned START_PC   = 1;

    // Interrupt channel indices
    localparam int unsigned INTR_STRM_F2G = 0;
    localparam int unsigned INTR_STRM_G2F = 1;
    localparam int unsigned INTR_PCFG_G2F = 2;

endpackage

// File: rtl/glb_tile_evt_pipe_if.sv
// Event/control bundle between the tile top and the event pipeline.
// master: drives clk_en, start/interrupt pulses, mask and clear.
// slave:  returns retimed clk_en, start/interrupt pulses and interrupt status.
interface glb_tile_evt_pipe_if #(
    parameter int unsigned NUM_START = 2,
    parameter int unsigned NUM_INTR  = 3,
    parameter int unsigned CNT_WIDTH = 4
);
    logic                          clk_en;
    logic                          clk_en_int;
    logic [NUM_START-1:0]          start_pulse_in;
    logic [NUM_START-1:0]          start_pulse_out;
    logic [NUM_INTR-1:0]           intr_pulse_in;
    logic [NUM_INTR-1:0]           intr_pulse_out;
    logic [NUM_INTR-1:0]           intr_mask;
    logic [NUM_INTR-1:0]           intr_clr;
    logic [NUM_INTR-1:0]           intr_pending;
    logic                          intr_level;
    logic [NUM_INTR*CNT_WIDTH-1:0] intr_ovf_cnt;

    modport master (
        output clk_en, start_pulse_in, intr_pulse_in, intr_mask, intr_clr,
        input  clk_en_int, start_pulse_out, intr_pulse_out, intr_pending, intr_level,
               intr_ovf_cnt
    );

    modport slave (
        input  clk_en, start_pulse_in, intr_pulse_in, intr_mask, intr_clr,
        output clk_en_int, start_pulse_out, intr_pulse_out, intr_pending, intr_level,
               intr_ovf_cnt
    );
endinterface

// File: rtl/glb_tile_evt_pipe_pulse_delay.sv
// glb_pulse_delay: WIDTH-bit shift register, DEPTH stages, synchronous reset.
// DEPTH = 0 collapses to a combinational wire.
// Ports: clk, reset (sync, active high), din (WIDTH), dout (WIDTH).
module glb_pulse_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/glb_tile_evt_pipe.sv
// Event/control pipeline between tile trigger/interrupt ports and glb_core.
// Retimes clk_en, start pulses and interrupt pulses; holds starts while the
// retimed clock enable is low; keeps sticky interrupt pending bits with mask,
// write-1-to-clear and saturating per-channel overflow counters.
// Ports: clk, reset (sync, active high), bus (slave side of glb_tile_evt_pipe_if).
module glb_tile_evt_pipe
    import global_buffer_param::*;
#(
    parameter int unsigned NUM_START   = GLB_NUM_START,
    parameter int unsigned NUM_INTR    = GLB_NUM_INTR,
    parameter int unsigned CLKEN_DEPTH = 1,
    parameter int unsigned START_DEPTH = 1,
    parameter int unsigned INTR_DEPTH  = 1,
    parameter int unsigned CNT_WIDTH   = 4
) (
    input logic              clk,
    input logic              reset,
    glb_tile_evt_pipe_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 clk_en_int;
    logic [NUM_START-1:0] start_dly;
    logic [NUM_START-1:0] start_out;
    logic [NUM_START-1:0] hold_q, hold_d;
    logic [NUM_INTR-1:0]  intr_dly;
    logic [NUM_INTR-1:0]  pending_q, pending_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_INTR];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_INTR];

    glb_pulse_delay #(.WIDTH(1), .DEPTH(CLKEN_DEPTH)) u_clken_dly (
        .clk   (clk),
        .reset (reset),
        .din   (bus.clk_en),
        .dout  (clk_en_int)
    );

    glb_pulse_delay #(.WIDTH(NUM_START), .DEPTH(START_DEPTH)) u_start_dly (
        .clk   (clk),
        .reset (reset),
        .din   (bus.start_pulse_in),
        .dout  (start_dly)
    );

    glb_pulse_delay #(.WIDTH(NUM_INTR), .DEPTH(INTR_DEPTH)) u_intr_dly (
        .clk   (clk),
        .reset (reset),
        .din   (bus.intr_pulse_in),
        .dout  (intr_dly)
    );

    // Starts seen while the core clock is off collapse into one held pulse,
    // released on the first enabled cycle.
    always_comb begin
        hold_d    = hold_q;
        start_out = '0;
        if (clk_en_int) begin
            start_out = start_dly | hold_q;
            hold_d    = '0;
        end else begin
            hold_d = hold_q | start_dly;
        end
    end

    // A new pulse always wins over a clear; a clear in that cycle only
    // resets the overflow count.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        for (int j = 0; j < int'(NUM_INTR); j++) begin
            if (intr_dly[j]) begin
                pending_d[j] = 1'b1;
                if (bus.intr_clr[j]) begin
                    cnt_d[j] = '0;
                end else if (pending_q[j] && (cnt_q[j] != CNT_MAX)) begin
                    cnt_d[j] = cnt_q[j] + CNT_WIDTH'(1);
                end
            end else if (bus.intr_clr[j]) begin
                pending_d[j] = 1'b0;
                cnt_d[j]     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            pending_q <= '0;
            for (int j = 0; j < int'(NUM_INTR); j++) cnt_q[j] <= '0;
        end else begin
            hold_q    <= hold_d;
            pending_q <= pending_d;
            for (int j = 0; j < int'(NUM_INTR); j++) cnt_q[j] <= cnt_d[j];
        end
    end

    always_comb begin
        bus.intr_ovf_cnt = '0;
        for (int j = 0; j < int'(NUM_INTR); j++) begin
            bus.intr_ovf_cnt[j*CNT_WIDTH +: CNT_WIDTH] = cnt_q[j];
        end
    end

    assign bus.clk_en_int      = clk_en_int;
    assign bus.start_pulse_out = start_out;
    assign bus.intr_pulse_out  = intr_dly;
    assign bus.intr_pending    = pending_q;
    assign bus.intr_level      = |(pending_q & ~bus.intr_mask);

endmodule

// File: tb/tb_glb_tile_evt_pipe.sv
module tb_glb_tile_evt_pipe;
    import global_buffer_param::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst2;
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    bit          sb_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    glb_tile_evt_pipe_if #(.NUM_START(2), .NUM_INTR(3), .CNT_WIDTH(4)) if1 ();
    glb_tile_evt_pipe_if #(.NUM_START(2), .NUM_INTR(3), .CNT_WIDTH(2)) if2 ();

    // Defaults
    glb_tile_evt_pipe #(
        .NUM_START(2), .NUM_INTR(3), .CLKEN_DEPTH(1), .START_DEPTH(1),
        .INTR_DEPTH(1), .CNT_WIDTH(4)
    ) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1.slave)
    );

    // Zero-latency start path, deep interrupt path, narrow counters
    glb_tile_evt_pipe #(
        .NUM_START(2), .NUM_INTR(3), .CLKEN_DEPTH(1), .START_DEPTH(0),
        .INTR_DEPTH(3), .CNT_WIDTH(2)
    ) u_dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (if2.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- table for u_dut1 ----------------
    typedef struct {
        logic       ce;
        logic [1:0] st;
        logic [2:0] ii;
        logic [2:0] mask;
        logic [2:0] clr;
        logic       e_ce;
        logic [1:0] e_st;
        logic [2:0] e_io;
        logic [2:0] e_pend;
        logic       e_lvl;
        logic [11:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic ce, logic [1:0] st, logic [2:0] ii, logic [2:0] mask,
                                logic [2:0] clr, logic e_ce, logic [1:0] e_st,
                                logic [2:0] e_io, logic [2:0] e_pend, logic e_lvl,
                                logic [11:0] e_cnt);
        vec_t v;
        v.ce = ce; v.st = st; v.ii = ii; v.mask = mask; v.clr = clr;
        v.e_ce = e_ce; v.e_st = e_st; v.e_io = e_io; v.e_pend = e_pend;
        v.e_lvl = e_lvl; v.e_cnt = e_cnt;
        return v;
    endfunction

    // ---------------- scoreboard for u_dut2 interrupt outputs ----------------
    typedef struct {
        int unsigned cyc;
        logic [2:0]  val;
    } sb_t;
    sb_t sb_q[$];

    always @(negedge clk) begin
        if (sb_on && (if2.intr_pulse_out != 3'b000)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_intr", {32'(cyc), 29'd0, if2.intr_pulse_out}, 64'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_intr_out", {32'(cyc), 29'd0, if2.intr_pulse_out},
                      {32'(e.cyc), 29'd0, e.val});
            end
        end
    end

    // One cycle on u_dut2: drive after the edge, return at the following negedge.
    task automatic step2(input logic ce, input logic [1:0] st, input logic [2:0] ii,
                         input logic [2:0] clr, input bit push);
        @(posedge clk);
        #1;
        if2.clk_en         = ce;
        if2.start_pulse_in = st;
        if2.intr_pulse_in  = ii;
        if2.intr_clr       = clr;
        if (push && ii != 3'b000) sb_q.push_back('{cyc + 3, ii});
        @(negedge clk);
    endtask

    function automatic logic [63:0] all_out2();
        return 64'({if2.clk_en_int, if2.start_pulse_out, if2.intr_pulse_out,
                    if2.intr_pending, if2.intr_level, if2.intr_ovf_cnt});
    endfunction

    vec_t vecs [22];
    logic [1:0] sat_exp [4];

    initial begin
        vecs[0]  = mk(1, 2'b00, 3'b000, 3'b000, 3'b000, 0, 2'b00, 3'b000, 3'b000, 0, 12'h000);
        vecs[1]  = mk(1, 2'b01, 3'b000, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b000, 0, 12'h000);
        vecs[2]  = mk(1, 2'b00, 3'b100, 3'b000, 3'b000, 1, 2'b01, 3'b000, 3'b000, 0, 12'h000);
        vecs[3]  = mk(1, 2'b00, 3'b000, 3'b000, 3'b000, 1, 2'b00, 3'b100, 3'b000, 0, 12'h000);
        vecs[4]  = mk(1, 2'b00, 3'b000, 3'b100, 3'b000, 1, 2'b00, 3'b000, 3'b100, 0, 12'h000);
        vecs[5]  = mk(1, 2'b00, 3'b000, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b100, 1, 12'h000);
        vecs[6]  = mk(1, 2'b00, 3'b100, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b100, 1, 12'h000);
        vecs[7]  = mk(1, 2'b00, 3'b100, 3'b000, 3'b000, 1, 2'b00, 3'b100, 3'b100, 1, 12'h000);
        vecs[8]  = mk(1, 2'b00, 3'b000, 3'b000, 3'b100, 1, 2'b00, 3'b100, 3'b100, 1, 12'h100);
        vecs[9]  = mk(1, 2'b00, 3'b000, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b100, 1, 12'h000);
        vecs[10] = mk(1, 2'b00, 3'b000, 3'b000, 3'b100, 1, 2'b00, 3'b000, 3'b100, 1, 12'h000);
        vecs[11] = mk(1, 2'b00, 3'b001, 3'b001, 3'b000, 1, 2'b00, 3'b000, 3'b000, 0, 12'h000);
        vecs[12] = mk(1, 2'b00, 3'b000, 3'b001, 3'b000, 1, 2'b00, 3'b001, 3'b000, 0, 12'h000);
        vecs[13] = mk(1, 2'b00, 3'b000, 3'b001, 3'b010, 1, 2'b00, 3'b000, 3'b001, 0, 12'h000);
        vecs[14] = mk(0, 2'b00, 3'b000, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b001, 1, 12'h000);
        vecs[15] = mk(0, 2'b10, 3'b000, 3'b000, 3'b000, 0, 2'b00, 3'b000, 3'b001, 1, 12'h000);
        vecs[16] = mk(0, 2'b00, 3'b000, 3'b000, 3'b000, 0, 2'b00, 3'b000, 3'b001, 1, 12'h000);
        vecs[17] = mk(0, 2'b10, 3'b000, 3'b000, 3'b000, 0, 2'b00, 3'b000, 3'b001, 1, 12'h000);
        vecs[18] = mk(1, 2'b00, 3'b000, 3'b000, 3'b000, 0, 2'b00, 3'b000, 3'b001, 1, 12'h000);
        vecs[19] = mk(1, 2'b00, 3'b000, 3'b000, 3'b000, 1, 2'b10, 3'b000, 3'b001, 1, 12'h000);
        vecs[20] = mk(1, 2'b00, 3'b000, 3'b000, 3'b001, 1, 2'b00, 3'b000, 3'b001, 1, 12'h000);
        vecs[21] = mk(1, 2'b00, 3'b000, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b000, 0, 12'h000);
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3;

        rst1 = 1'b1; rst2 = 1'b1;
        if1.clk_en = 1'b1; if1.start_pulse_in = 2'b11; if1.intr_pulse_in = 3'b111;
        if1.intr_mask = 3'b000; if1.intr_clr = 3'b000;
        if2.clk_en = 1'b0; if2.start_pulse_in = 2'b00; if2.intr_pulse_in = 3'b000;
        if2.intr_mask = 3'b000; if2.intr_clr = 3'b000;

        // Reset held with busy inputs: every output must read 0
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("dut1_reset_outputs",
              64'({if1.clk_en_int, if1.start_pulse_out, if1.intr_pulse_out,
                   if1.intr_pending, if1.intr_level, if1.intr_ovf_cnt}), 64'd0);

        @(posedge clk); #1;
        rst1 = 1'b0;
        if1.clk_en = 1'b0; if1.start_pulse_in = 2'b00; if1.intr_pulse_in = 3'b000;

        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            if1.clk_en         = vecs[i].ce;
            if1.start_pulse_in = vecs[i].st;
            if1.intr_pulse_in  = vecs[i].ii;
            if1.intr_mask      = vecs[i].mask;
            if1.intr_clr       = vecs[i].clr;
            @(negedge clk);
            check($sformatf("dut1_row%0d", i),
                  64'({if1.clk_en_int, if1.start_pulse_out, if1.intr_pulse_out,
                       if1.intr_pending, if1.intr_level, if1.intr_ovf_cnt}),
                  64'({vecs[i].e_ce, vecs[i].e_st, vecs[i].e_io, vecs[i].e_pend,
                       vecs[i].e_lvl, vecs[i].e_cnt}));
        end

        // ---------------- u_dut2 ----------------
        rst2  = 1'b0;
        sb_on = 1'b1;
        step2(1, 2'b00, 3'b000, 3'b000, 1);
        step2(1, 2'b01, 3'b000, 3'b000, 1);
        check("start_depth0_same_cycle", 64'(if2.start_pulse_out[START_STRM]), 64'd1);
        step2(1, 2'b00, 3'b000, 3'b000, 1);
        check("start_depth0_single", 64'(if2.start_pulse_out), 64'd0);

        // Overflow saturation on channel 0
        for (int k = 0; k < 5; k++) step2(1, 2'b00, 3'b001, 3'b000, 1);
        check("sat_pending", 64'(if2.intr_pending[INTR_STRM_F2G]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step2(1, 2'b00, 3'b000, 3'b000, 1);
            check($sformatf("sat_cnt%0d", k), 64'(if2.intr_ovf_cnt[0 +: 2]), 64'(sat_exp[k]));
        end
        step2(1, 2'b00, 3'b000, 3'b001, 1);
        step2(1, 2'b00, 3'b000, 3'b000, 1);
        check("sat_clear", 64'({if2.intr_pending[INTR_STRM_F2G], if2.intr_ovf_cnt[0 +: 2]}),
              64'd0);

        // Set/clear collision on channel 1
        for (int k = 0; k < 4; k++) step2(1, 2'b00, 3'b010, 3'b000, 1);
        step2(1, 2'b00, 3'b000, 3'b000, 1);
        step2(1, 2'b00, 3'b000, 3'b000, 1);
        step2(1, 2'b00, 3'b000, 3'b010, 1);
        check("coll_before", 64'({if2.intr_pending[INTR_STRM_G2F], if2.intr_ovf_cnt[2 +: 2]}),
              64'({1'b1, 2'd2}));
        step2(1, 2'b00, 3'b000, 3'b000, 1);
        check("coll_after", 64'({if2.intr_pending[INTR_STRM_G2F], if2.intr_ovf_cnt[2 +: 2]}),
              64'({1'b1, 2'd0}));
        step2(1, 2'b00, 3'b000, 3'b010, 1);
        step2(1, 2'b00, 3'b000, 3'b000, 1);
        check("coll_cleared", 64'(if2.intr_pending[INTR_STRM_G2F]), 64'd0);

        // Random pulses through the scoreboard
        for (int k = 0; k < 24; k++) step2(1, 2'b00, 3'($urandom_range(0, 7)), 3'b111, 1);
        for (int k = 0; k < 4; k++) step2(1, 2'b00, 3'b000, 3'b111, 1);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        step2(1, 2'b00, 3'b000, 3'b000, 1);

        // Reset mid-flight: held start and in-flight interrupt are discarded
        step2(0, 2'b00, 3'b000, 3'b000, 0);
        step2(0, 2'b01, 3'b100, 3'b000, 0);
        step2(0, 2'b00, 3'b000, 3'b000, 0);
        rst2 = 1'b1;
        step2(0, 2'b00, 3'b000, 3'b000, 0);
        check("dut2_reset_outputs", all_out2(), 64'd0);
        rst2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step2(1, 2'b00, 3'b000, 3'b000, 0);
            check($sformatf("post_reset%0d", k),
                  64'({if2.start_pulse_out, if2.intr_pending[INTR_PCFG_G2F]}), 64'd0);
        end
        sb_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
